// File: rtl/uc_seq.sv
// Sequenced control unit: opcode/z decode gated by an IDLE/RUN/STEP/HALT/ERR
// state machine, plus a wrapping retired-instruction counter.
module uc_seq #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  HALT_OP = 6'b000001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_HALT, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;

  logic       is_halt, legal, active;
  logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_pc_we;
  logic [2:0] dec_op;

  // Raw decode of the opcode, independent of state.
  always_comb begin
    is_halt   = (Opcode == HALT_OP);
    legal     = 1'b0;
    dec_s_inc = 1'b0;
    dec_s_inm = 1'b0;
    dec_we3   = 1'b0;
    dec_wez   = 1'b0;
    dec_pc_we = 1'b0;
    dec_op    = '0;
    if (!is_halt) begin
      casez (Opcode)
        6'b1?????: begin
          legal = 1'b1; dec_s_inc = 1'b1; dec_we3 = 1'b1; dec_wez = 1'b1;
          dec_op = Opcode[4:2]; dec_pc_we = 1'b1;
        end
        6'b0001??: begin
          legal = 1'b1; dec_s_inc = 1'b1; dec_s_inm = 1'b1; dec_we3 = 1'b1;
          dec_pc_we = 1'b1;
        end
        6'b000000: begin
          legal = 1'b1; dec_s_inc = 1'b1; dec_pc_we = 1'b1;
        end
        6'b010000: begin
          legal = 1'b1; dec_pc_we = 1'b1;
        end
        6'b010001: begin
          legal = 1'b1; dec_s_inc = ~z; dec_pc_we = 1'b1;
        end
        6'b010010: begin
          legal = 1'b1; dec_s_inc = z; dec_pc_we = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Controls are live only while executing and never during a reset cycle.
  always_comb begin
    active = reset && ((state_q == S_RUN) || (state_q == S_STEP));
    s_inc  = active & dec_s_inc;
    s_inm  = active & dec_s_inm;
    we3    = active & dec_we3;
    wez    = active & dec_wez;
    pc_we  = active & dec_pc_we;
    Op     = active ? dec_op : 3'b000;
  end

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    if (active && legal) icount_d = icount_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (run)       state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_RUN: begin
        if (is_halt)     state_d = S_HALT;
        else if (!legal) state_d = S_ERR;
        else if (!run)   state_d = S_IDLE;
      end
      S_STEP: begin
        if (is_halt)     state_d = S_HALT;
        else if (!legal) state_d = S_ERR;
        else             state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_STEP);
  assign halted = (state_q == S_HALT);
  assign err    = (state_q == S_ERR);
  assign icount = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed scenarios followed by random
// stimulus, compared each cycle against a behavioural model of the CPU control.
module tb_uc_seq;

  logic        clk = 1'b0;
  logic        reset, z, run, step;
  logic [5:0]  Opcode;

  logic        s_inc, s_inm, we3, wez, pc_we, busy, halted, err;
  logic [2:0]  Op;
  logic [15:0] icount;

  logic        s_inc4, s_inm4, we34, wez4, pc_we4, busy4, halted4, err4;
  logic [2:0]  Op4;
  logic [3:0]  icount4;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model: mode 0=idle 1=run 2=step 3=halt 4=err; count is unbounded.
  int unsigned m_mode;
  int unsigned m_count;

  always #5 clk = ~clk;

  uc_seq #(.CNT_W(16), .HALT_OP(6'b000001)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op), .pc_we(pc_we),
    .busy(busy), .halted(halted), .err(err), .icount(icount)
  );

  uc_seq #(.CNT_W(4), .HALT_OP(6'b000001)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(Op4), .pc_we(pc_we4),
    .busy(busy4), .halted(halted4), .err(err4), .icount(icount4)
  );

  // Instruction class: 0 alu,1 li,2 nop,3 j,4 jz,5 jnz,6 halt,7 illegal.
  function automatic int unsigned kind_of(input logic [5:0] o);
    int unsigned v;
    v = int'(o);
    if (v == 1)       return 6;
    if (v >= 32)      return 0;
    if (v / 4 == 1)   return 1;
    if (v == 0)       return 2;
    if (v == 16)      return 3;
    if (v == 17)      return 4;
    if (v == 18)      return 5;
    return 7;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, check the Mealy outputs, then advance the model.
  task automatic cyc(input logic r, input logic s, input logic [5:0] o,
                     input logic zz, input logic rs);
    int unsigned k;
    logic        executing;
    logic        e_inc, e_inm, e_we3, e_wez, e_pc;
    logic [2:0]  e_op;
    logic [10:0] e_vec;
    run = r; step = s; Opcode = o; z = zz; reset = rs;
    #3;
    k = kind_of(o);
    executing = rs && (m_mode == 1 || m_mode == 2);
    e_inc = 0; e_inm = 0; e_we3 = 0; e_wez = 0; e_pc = 0; e_op = 3'd0;
    if (executing && k < 6) begin
      e_pc = 1;
      case (k)
        0: begin e_inc = 1; e_we3 = 1; e_wez = 1; e_op = 3'((int'(o) - 32) / 4); end
        1: begin e_inc = 1; e_inm = 1; e_we3 = 1; end
        2: e_inc = 1;
        4: e_inc = !zz;
        5: e_inc = zz;
        default: ;
      endcase
    end
    chk("s_inc", 32'(s_inc), 32'(e_inc));
    chk("s_inm", 32'(s_inm), 32'(e_inm));
    chk("we3",   32'(we3),   32'(e_we3));
    chk("wez",   32'(wez),   32'(e_wez));
    chk("Op",    32'(Op),    32'(e_op));
    chk("pc_we", 32'(pc_we), 32'(e_pc));
    chk("busy",   32'(busy),   32'(m_mode == 1 || m_mode == 2));
    chk("halted", 32'(halted), 32'(m_mode == 3));
    chk("err",    32'(err),    32'(m_mode == 4));
    chk("icount", 32'(icount), m_count % 65536);
    chk("icount4", 32'(icount4), m_count % 16);
    e_vec = {e_inc, e_inm, e_we3, e_wez, e_op, e_pc,
             1'(m_mode == 1 || m_mode == 2), 1'(m_mode == 3), 1'(m_mode == 4)};
    chk("ctl4", 32'({s_inc4, s_inm4, we34, wez4, Op4, pc_we4, busy4, halted4, err4}),
        32'(e_vec));
    @(posedge clk);
    if (!rs) begin
      m_mode = 0; m_count = 0;
    end else begin
      if (executing && k < 6) m_count++;
      case (m_mode)
        0: m_mode = r ? 1 : (s ? 2 : 0);
        1: m_mode = (k == 6) ? 3 : (k == 7) ? 4 : (r ? 1 : 0);
        2: m_mode = (k == 6) ? 3 : (k == 7) ? 4 : 0;
        default: ;
      endcase
    end
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    int unsigned p;
    p = $urandom_range(0, 59);
    if (p == 0)  return 6'd1;
    if (p == 1)  return 6'(8 + $urandom_range(0, 7));
    if (p == 2)  return 6'(19 + $urandom_range(0, 12));
    if (p < 20)  return 6'(32 + $urandom_range(0, 31));
    if (p < 30)  return 6'(4 + $urandom_range(0, 3));
    if (p < 38)  return 6'd0;
    if (p < 44)  return 6'd16;
    if (p < 52)  return 6'd17;
    return 6'd18;
  endfunction

  initial begin
    m_mode = 0; m_count = 0;
    reset = 0; run = 0; step = 0; Opcode = 6'd0; z = 0;
    @(posedge clk); #1;
    cyc(0, 0, 6'd0, 0, 0);
    cyc(0, 0, 6'd0, 0, 0);

    // Free-run ALU op
    cyc(1, 0, 6'b101100, 0, 1);
    repeat (3) cyc(1, 0, 6'b101100, 0, 1);
    chk("run3_icount", 32'(icount), 32'd3);
    // Conditional jumps
    cyc(1, 0, 6'b010001, 1, 1);
    cyc(1, 0, 6'b010001, 0, 1);
    cyc(1, 0, 6'b010010, 1, 1);
    cyc(1, 0, 6'b010010, 0, 1);
    cyc(0, 0, 6'd0, 0, 1);
    // Single step of li
    cyc(0, 1, 6'b000100, 0, 1);
    cyc(0, 0, 6'b000100, 0, 1);
    cyc(0, 0, 6'b000100, 0, 1);
    chk("step_idle", 32'(busy), 32'd0);
    // Run and step together: run wins
    cyc(1, 1, 6'd0, 0, 1);
    cyc(1, 1, 6'd0, 0, 1);
    cyc(1, 0, 6'b000001, 0, 1);
    cyc(1, 0, 6'd0, 0, 1);
    cyc(1, 0, 6'd0, 0, 1);
    chk("halt_sticky", 32'(halted), 32'd1);
    cyc(1, 0, 6'd0, 0, 0);
    cyc(0, 0, 6'd0, 0, 1);
    chk("halt_reset_cnt", 32'(icount), 32'd0);
    // Illegal opcode
    cyc(1, 0, 6'd0, 0, 1);
    cyc(1, 0, 6'b001000, 0, 1);
    cyc(1, 0, 6'd0, 0, 1);
    chk("err_sticky", 32'(err), 32'd1);
    cyc(0, 0, 6'd0, 0, 0);
    // Wrap of the 4-bit instance
    cyc(1, 0, 6'd0, 0, 1);
    repeat (17) cyc(1, 0, 6'd0, 0, 1);
    chk("wrap4", 32'(icount4), 32'd1);
    // Reset mid-instruction
    cyc(1, 0, 6'b111111, 1, 0);
    cyc(0, 0, 6'd0, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      logic rs;
      if (m_mode >= 3) rs = ($urandom_range(0, 3) != 0);
      else             rs = ($urandom_range(0, 99) != 0);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          rand_op(), 1'($urandom_range(0, 1)), rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
